// File: rtl/execute_stage_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | execute_stage_pipe : registered execute stage, valid/ready, shift-add MUL   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module execute_stage_pipe #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int MUL_EN = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [3:0]        i_opcode,
   input  logic [DATA_W-1:0] i_srcdata_1,
   input  logic [DATA_W-1:0] i_srcdata_2,
   input  logic [ADDR_W-1:0] i_destadd,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_write_en,
   output logic [ADDR_W-1:0] o_write_add,
   output logic [DATA_W-1:0] o_write_data,
   output logic [3:0]        o_flags,
   output logic              o_busy
);

   localparam int c_SH_W  = $clog2(DATA_W);
   localparam int c_CNT_W = $clog2(DATA_W);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);

   localparam logic [3:0] c_OP_ADD = 4'h1;
   localparam logic [3:0] c_OP_SUB = 4'h2;
   localparam logic [3:0] c_OP_AND = 4'h3;
   localparam logic [3:0] c_OP_OR  = 4'h4;
   localparam logic [3:0] c_OP_XOR = 4'h5;
   localparam logic [3:0] c_OP_NOT = 4'h6;
   localparam logic [3:0] c_OP_SHL = 4'h7;
   localparam logic [3:0] c_OP_SHR = 4'h8;
   localparam logic [3:0] c_OP_MUL = 4'h9;
   localparam logic [3:0] c_OP_MOV = 4'hA;
   localparam logic [3:0] c_OP_CMP = 4'hB;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

   state_t r_state, w_state_next;

   logic              r_valid, r_we;
   logic [ADDR_W-1:0] r_add, r_mul_add;
   logic [DATA_W-1:0] r_data, r_mul_b;
   logic [3:0]        r_flags;
   logic [2*DATA_W-1:0] r_mul_a, r_acc, w_mul_sum;
   logic [c_CNT_W-1:0]  r_cnt;

   logic              w_accept, w_is_mul, w_mul_done;
   logic [c_SH_W-1:0] w_sh;
   logic [DATA_W:0]   w_add, w_sub, w_shl, w_shr;
   logic [DATA_W-1:0] w_res, w_mul_lo;
   logic              w_c, w_v, w_we, w_nz;
   logic [3:0]        w_flags, w_mul_flags;

   assign o_ready  = i_rst_n && (r_state == ST_IDLE) && (!r_valid || i_ready);
   assign w_accept = i_valid && o_ready && !i_flush;
   assign w_is_mul = (i_opcode == c_OP_MUL) && (MUL_EN != 0);

   assign w_sh  = i_srcdata_2[c_SH_W-1:0];
   assign w_add = {1'b0, i_srcdata_1} + {1'b0, i_srcdata_2};
   assign w_sub = {1'b0, i_srcdata_1} - {1'b0, i_srcdata_2};
   // Extra bit beside the operand catches the last bit shifted out.
   assign w_shl = {1'b0, i_srcdata_1} << w_sh;
   assign w_shr = {i_srcdata_1, 1'b0} >> w_sh;

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_we  = 1'b0;
      w_nz  = 1'b0;
      case (i_opcode)
         c_OP_ADD: begin
            w_res = w_add[DATA_W-1:0];
            w_c   = w_add[DATA_W];
            w_v   = (i_srcdata_1[DATA_W-1] == i_srcdata_2[DATA_W-1]) &&
                    (w_res[DATA_W-1] != i_srcdata_1[DATA_W-1]);
            w_we  = 1'b1;
            w_nz  = 1'b1;
         end
         c_OP_SUB, c_OP_CMP: begin
            w_res = w_sub[DATA_W-1:0];
            w_c   = w_sub[DATA_W];
            w_v   = (i_srcdata_1[DATA_W-1] != i_srcdata_2[DATA_W-1]) &&
                    (w_res[DATA_W-1] != i_srcdata_1[DATA_W-1]);
            w_we  = (i_opcode == c_OP_SUB);
            w_nz  = 1'b1;
         end
         c_OP_AND: begin w_res = i_srcdata_1 & i_srcdata_2; w_we = 1'b1; w_nz = 1'b1; end
         c_OP_OR:  begin w_res = i_srcdata_1 | i_srcdata_2; w_we = 1'b1; w_nz = 1'b1; end
         c_OP_XOR: begin w_res = i_srcdata_1 ^ i_srcdata_2; w_we = 1'b1; w_nz = 1'b1; end
         c_OP_NOT: begin w_res = ~i_srcdata_1;              w_we = 1'b1; w_nz = 1'b1; end
         c_OP_MOV: begin w_res = i_srcdata_2;               w_we = 1'b1; w_nz = 1'b1; end
         c_OP_SHL: begin
            w_res = w_shl[DATA_W-1:0];
            w_c   = w_shl[DATA_W];
            w_we  = 1'b1;
            w_nz  = 1'b1;
         end
         c_OP_SHR: begin
            w_res = w_shr[DATA_W:1];
            w_c   = w_shr[0];
            w_we  = 1'b1;
            w_nz  = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_flags = {w_nz & w_res[DATA_W-1], w_nz & (w_res == '0), w_c, w_v};

   assign w_mul_sum   = r_acc + (r_mul_b[0] ? r_mul_a : '0);
   assign w_mul_lo    = w_mul_sum[DATA_W-1:0];
   assign w_mul_flags = {w_mul_lo[DATA_W-1], (w_mul_lo == '0), |w_mul_sum[2*DATA_W-1:DATA_W], 1'b0};
   assign w_mul_done  = (r_state == ST_MUL_BUSY) && (r_cnt == c_CNT_LAST) && !i_flush;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (i_flush) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:     if (w_accept && w_is_mul) w_state_next = ST_MUL_BUSY;
            ST_MUL_BUSY: if (r_cnt == c_CNT_LAST)  w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid   <= 1'b0;
         r_we      <= 1'b0;
         r_add     <= '0;
         r_data    <= '0;
         r_flags   <= '0;
         r_mul_a   <= '0;
         r_mul_b   <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_mul_add <= '0;
      end else begin
         // One multiplier bit per cycle; the final bit is folded in as the slot loads.
         if (w_accept && w_is_mul) begin
            r_mul_a   <= {{DATA_W{1'b0}}, i_srcdata_1};
            r_mul_b   <= i_srcdata_2;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_mul_add <= i_destadd;
         end else if (r_state == ST_MUL_BUSY) begin
            r_acc   <= w_mul_sum;
            r_mul_a <= r_mul_a << 1;
            r_mul_b <= r_mul_b >> 1;
            r_cnt   <= r_cnt + 1'b1;
         end

         if (i_flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
         end else if (w_accept && !w_is_mul) begin
            r_valid <= 1'b1;
            r_we    <= w_we;
            r_add   <= i_destadd;
            r_data  <= w_res;
            r_flags <= w_flags;
         end else if (w_mul_done) begin
            r_valid <= 1'b1;
            r_we    <= 1'b1;
            r_add   <= r_mul_add;
            r_data  <= w_mul_lo;
            r_flags <= w_mul_flags;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
         end
      end
   end

   assign o_valid      = r_valid;
   assign o_write_en   = r_we;
   assign o_write_add  = r_add;
   assign o_write_data = r_data;
   assign o_flags      = r_flags;
   assign o_busy       = (r_state == ST_MUL_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_execute_stage_pipe : randomized and directed checks against a model      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_execute_stage_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid_in = 1'b0;
   logic       ready_out;
   logic [3:0] opcode = '0;
   logic [7:0] src1 = '0;
   logic [7:0] src2 = '0;
   logic [3:0] dest = '0;
   logic       flush = 1'b0;
   logic       valid_out;
   logic       ready_in = 1'b1;
   logic       we;
   logic [3:0] wadd;
   logic [7:0] wdata;
   logic [3:0] flags;
   logic       busy;

   int total = 0;
   int bad = 0;

   execute_stage_pipe #(.DATA_W(8), .ADDR_W(4), .MUL_EN(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in), .o_ready(ready_out),
      .i_opcode(opcode), .i_srcdata_1(src1), .i_srcdata_2(src2), .i_destadd(dest),
      .i_flush(flush), .o_valid(valid_out), .i_ready(ready_in), .o_write_en(we),
      .o_write_add(wadd), .o_write_data(wdata), .o_flags(flags), .o_busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int sgn8(int x);
      return (x > 127) ? x - 256 : x;
   endfunction

   // Returns {we, data[7:0], N, Z, C, V}
   function automatic logic [12:0] model(int op, int a, int b);
      int r, c, v, w, s, sh, nz;
      r = 0; c = 0; v = 0; w = 1; nz = 1; sh = b % 8;
      case (op)
         1:  begin r = a + b; c = (r > 255); s = sgn8(a) + sgn8(b); v = (s > 127 || s < -128); end
         2, 11: begin r = a - b; c = (a < b); s = sgn8(a) - sgn8(b); v = (s > 127 || s < -128);
                      w = (op == 2); end
         3:  r = a & b;
         4:  r = a | b;
         5:  r = a ^ b;
         6:  r = ~a;
         7:  begin r = a << sh; c = (sh != 0) ? ((a >> (8 - sh)) & 1) : 0; end
         8:  begin r = a >> sh; c = (sh != 0) ? ((a >> (sh - 1)) & 1) : 0; end
         9:  begin r = a * b; c = ((r >> 8) != 0); end
         10: r = b;
         default: begin w = 0; nz = 0; end
      endcase
      r = r & 255;
      return {w[0], r[7:0], nz[0] & r[7], nz[0] & (r == 0), c[0], v[0]};
   endfunction

   task automatic drive(input int op, input int a, input int b, input int d);
      valid_in = 1'b1;
      opcode   = op[3:0];
      src1     = a[7:0];
      src2     = b[7:0];
      dest     = d[3:0];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if ({valid_out, we, busy, ready_out, wadd, wdata, flags} !== 20'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", {valid_out, we, busy, ready_out, wadd, wdata, flags});
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_release ready=%b valid=%b want ready=1 valid=0", ready_out, valid_out);
      end
   endtask

   task automatic test_add();
      @(negedge clk); drive(1, 8'h7F, 8'h01, 3);
      @(negedge clk); valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b1 || we !== 1'b1 || wdata !== 8'h80 || wadd !== 4'd3 || flags !== 4'b1001) begin
         bad++;
         $display("FAIL add v=%b we=%b d=%h a=%0d f=%b want v=1 we=1 d=80 a=3 f=1001",
                  valid_out, we, wdata, wadd, flags);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); drive(2, 8'h05, 8'h05, 4);
      @(negedge clk); drive(11, 8'h03, 8'h07, 5);
      total++;
      if (valid_out !== 1'b1 || we !== 1'b1 || wdata !== 8'h00 || flags !== 4'b0100) begin
         bad++;
         $display("FAIL sub v=%b we=%b d=%h f=%b want v=1 we=1 d=00 f=0100", valid_out, we, wdata, flags);
      end
      @(negedge clk); valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b1 || we !== 1'b0 || wdata !== 8'hFC || flags !== 4'b1010) begin
         bad++;
         $display("FAIL cmp v=%b we=%b d=%h f=%b want v=1 we=0 d=FC f=1010", valid_out, we, wdata, flags);
      end
   endtask

   task automatic test_mul();
      int busy_bad;
      busy_bad = 0;
      @(negedge clk); drive(9, 8'h12, 8'h10, 7);
      @(negedge clk); valid_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         if (busy !== 1'b1 || ready_out !== 1'b0 || valid_out !== 1'b0) busy_bad++;
      end
      total++;
      if (busy_bad != 0) begin
         bad++;
         $display("FAIL mul_busy bad_cycles=%0d want 0", busy_bad);
      end
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || busy !== 1'b0 || we !== 1'b1 || wdata !== 8'h20 || wadd !== 4'd7 || flags !== 4'b0010) begin
         bad++;
         $display("FAIL mul_result v=%b busy=%b we=%b d=%h a=%0d f=%b want v=1 busy=0 we=1 d=20 a=7 f=0010",
                  valid_out, busy, we, wdata, wadd, flags);
      end
   endtask

   task automatic test_backpressure();
      int hold_bad;
      hold_bad = 0;
      @(negedge clk); ready_in = 1'b0; drive(1, 8'h20, 8'h22, 9);
      @(negedge clk); valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (valid_out !== 1'b1 || wdata !== 8'h42 || wadd !== 4'd9 || flags !== 4'b0000 || ready_out !== 1'b0)
            hold_bad++;
      end
      total++;
      if (hold_bad != 0) begin
         bad++;
         $display("FAIL hold bad_cycles=%0d want 0", hold_bad);
      end
      ready_in = 1'b1; drive(5, 8'hF0, 8'hFF, 2);
      @(negedge clk); valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b1 || wdata !== 8'h0F || wadd !== 4'd2 || flags !== 4'b0000) begin
         bad++;
         $display("FAIL xor_after_hold v=%b d=%h a=%0d f=%b want v=1 d=0F a=2 f=0000",
                  valid_out, wdata, wadd, flags);
      end
   endtask

   task automatic test_flush();
      int rise;
      rise = 0;
      @(negedge clk); drive(9, 8'hFF, 8'hFF, 1);
      @(negedge clk); valid_in = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      flush = 1'b1; drive(1, 8'h01, 8'h01, 1);
      @(negedge clk); flush = 1'b0; valid_in = 1'b0;
      total++;
      if (busy !== 1'b0 || ready_out !== 1'b1 || valid_out !== 1'b0) begin
         bad++;
         $display("FAIL flush_mul busy=%b ready=%b valid=%b want 0 1 0", busy, ready_out, valid_out);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (valid_out !== 1'b0) rise++;
      end
      total++;
      if (rise != 0) begin
         bad++;
         $display("FAIL flush_no_result valid_cycles=%0d want 0", rise);
      end
      flush = 1'b1; drive(1, 8'h01, 8'h02, 6);
      @(negedge clk); flush = 1'b0; valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b0 || we !== 1'b0) begin
         bad++;
         $display("FAIL flush_blocks_accept valid=%b we=%b want 0 0", valid_out, we);
      end
   endtask

   task automatic test_shift_reserved();
      @(negedge clk); drive(7, 8'h81, 8'h01, 1);
      @(negedge clk); drive(8, 8'h01, 8'h00, 2);
      total++;
      if (wdata !== 8'h02 || flags[1] !== 1'b1 || we !== 1'b1) begin
         bad++;
         $display("FAIL shl d=%h C=%b we=%b want d=02 C=1 we=1", wdata, flags[1], we);
      end
      @(negedge clk); drive(14, 8'h55, 8'hAA, 3);
      total++;
      if (wdata !== 8'h01 || flags[1] !== 1'b0 || we !== 1'b1) begin
         bad++;
         $display("FAIL shr d=%h C=%b we=%b want d=01 C=0 we=1", wdata, flags[1], we);
      end
      @(negedge clk); valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b1 || we !== 1'b0 || wdata !== 8'h00 || flags !== 4'b0000) begin
         bad++;
         $display("FAIL reserved v=%b we=%b d=%h f=%b want v=1 we=0 d=00 f=0000", valid_out, we, wdata, flags);
      end
   endtask

   task automatic test_reset_mid_mul();
      @(negedge clk); drive(9, 8'h33, 8'h44, 5);
      @(negedge clk); valid_in = 1'b0;
      @(negedge clk); @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({valid_out, we, busy, ready_out, wadd, wdata, flags} !== 20'h0) begin
         bad++;
         $display("FAIL reset_mid_mul got=%h want=0", {valid_out, we, busy, ready_out, wadd, wdata, flags});
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 10; i++) @(negedge clk);
      total++;
      if (valid_out !== 1'b0 || busy !== 1'b0 || ready_out !== 1'b1) begin
         bad++;
         $display("FAIL after_reset_mid_mul v=%b busy=%b ready=%b want 0 0 1", valid_out, busy, ready_out);
      end
   endtask

   task automatic test_random_single();
      int op, a, b, d, errs, wait_cnt;
      logic [12:0] exp;
      errs = 0;
      for (int n = 0; n < 40; n++) begin
         op = $urandom_range(0, 15); a = $urandom_range(0, 255);
         b = $urandom_range(0, 255); d = $urandom_range(0, 15);
         exp = model(op, a, b);
         @(negedge clk); drive(op, a, b, d);
         @(negedge clk); valid_in = 1'b0;
         wait_cnt = 0;
         while (valid_out !== 1'b1 && wait_cnt < 12) begin
            @(negedge clk); wait_cnt++;
         end
         total++;
         if (valid_out !== 1'b1 || {we, wdata, flags} !== exp || wadd !== d[3:0]) begin
            bad++; errs++;
            if (errs < 6)
               $display("FAIL rand op=%0d a=%h b=%h v=%b got=%h want=%h add=%0d want=%0d",
                        op, a, b, valid_out, {we, wdata, flags}, exp, wadd, d);
         end
      end
   endtask

   task automatic test_random_stream();
      int op, a, b, d;
      logic [12:0] exp;
      logic [3:0]  exp_add;
      logic        have;
      have = 1'b0; exp = '0; exp_add = '0;
      for (int n = 0; n < 30; n++) begin
         do op = $urandom_range(0, 15); while (op == 9);
         a = $urandom_range(0, 255); b = $urandom_range(0, 255); d = $urandom_range(0, 15);
         @(negedge clk);
         if (have) begin
            total++;
            if (valid_out !== 1'b1 || {we, wdata, flags} !== exp || wadd !== exp_add) begin
               bad++;
               $display("FAIL stream v=%b got=%h want=%h add=%0d want=%0d",
                        valid_out, {we, wdata, flags}, exp, wadd, exp_add);
            end
         end
         drive(op, a, b, d);
         exp = model(op, a, b); exp_add = d[3:0]; have = 1'b1;
      end
      @(negedge clk); valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b1 || {we, wdata, flags} !== exp || wadd !== exp_add) begin
         bad++;
         $display("FAIL stream_last v=%b got=%h want=%h", valid_out, {we, wdata, flags}, exp);
      end
      @(negedge clk);
      total++;
      if (valid_out !== 1'b0 || we !== 1'b0) begin
         bad++;
         $display("FAIL drain v=%b we=%b want 0 0", valid_out, we);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_mul();
      test_backpressure();
      test_flush();
      test_shift_reserved();
      test_reset_mid_mul();
      test_random_single();
      test_random_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
